// File: rtl/axis_rs232_tx_scheduler_if.sv
// Stream bundle between the channel sources, the scheduler and the RS232 transmit chain.
// Input side: CHANNELS byte lanes with per-lane valid/ready. Output side: one byte stream.
interface axis_rs232_tx_scheduler_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [8*CHANNELS-1:0] idata;
    logic [CHANNELS-1:0]   ivalid;
    logic [CHANNELS-1:0]   iready;
    logic [7:0]            odata;
    logic                  ovalid;
    logic                  oready;
    logic [CHANNELS-1:0]   grant;
    logic                  busy;

    // Scheduler side.
    modport slave (
        input  idata,
        input  ivalid,
        input  oready,
        output iready,
        output odata,
        output ovalid,
        output grant,
        output busy
    );

    // Environment side: drives the sources and the downstream ready.
    modport master (
        output idata,
        output ivalid,
        output oready,
        input  iready,
        input  odata,
        input  ovalid,
        input  grant,
        input  busy
    );
endinterface

// File: rtl/axis_rs232_tx_scheduler.sv
// Round-robin scheduler sharing one RS232 transmit byte stream among CHANNELS sources.
// Each grant emits a header byte 8'hF0|k followed by up to BURST data bytes of channel k.
// Optional feature macro TX_TRAILER_EN: when defined, every frame ends with a byte-count
// trailer (1..BURST); when undefined, frames are header + data only.
module axis_rs232_tx_scheduler #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned BURST    = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    axis_rs232_tx_scheduler_if.slave        bus
);

    localparam int unsigned IdxW     = $clog2(CHANNELS);
    localparam logic [7:0]  BurstMax = 8'(BURST);

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
`ifdef TX_TRAILER_EN
        StData,
        StTrailer
`else
        StData
`endif
    } state_t;

    state_t              state_q;
    logic [IdxW-1:0]     last_q;     // last granted channel; owner while a grant is active
    logic [7:0]          count_q;
    logic [7:0]          odata_q;
    logic                ovalid_q;
    logic [CHANNELS-1:0] grant_q;

    logic                accept;
    logic                room;
    logic                hit;
    logic [IdxW-1:0]     pick;
    logic [IdxW:0]       cand;
    logic                sel_valid;
    logic [7:0]          sel_byte;
    logic                take;

    assign accept = !ovalid_q || bus.oready;
    assign room   = (count_q != BurstMax);
    assign take   = (state_q == StData) && accept && room && sel_valid;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        cand = '0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            cand = {1'b0, last_q} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(CHANNELS)) begin
                cand = cand - (IdxW+1)'(CHANNELS);
            end
            if (!hit && bus.ivalid[cand[IdxW-1:0]]) begin
                hit  = 1'b1;
                pick = cand[IdxW-1:0];
            end
        end
    end

    // Select the owner's lane.
    always_comb begin
        sel_valid = 1'b0;
        sel_byte  = 8'h00;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (last_q == IdxW'(c)) begin
                sel_valid = bus.ivalid[c];
                sel_byte  = bus.idata[8*c +: 8];
            end
        end
    end

    // Ready goes only to the owner, only while data may be loaded and the burst has room.
    always_comb begin
        bus.iready = '0;
        if ((state_q == StData) && accept && room) begin
            bus.iready = grant_q;
        end
    end

    assign bus.odata  = odata_q;
    assign bus.ovalid = ovalid_q;
    assign bus.grant  = grant_q;
    assign bus.busy   = (state_q != StIdle);

    // Scheduler FSM and registered output stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            last_q   <= IdxW'(CHANNELS - 1);
            count_q  <= 8'h00;
            odata_q  <= 8'h00;
            ovalid_q <= 1'b0;
            grant_q  <= '0;
        end else begin
            // A completed transfer empties the output register unless reloaded below.
            if (ovalid_q && bus.oready) begin
                ovalid_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (hit) begin
                        grant_q <= CHANNELS'(1) << pick;
                        last_q  <= pick;
                        state_q <= StHeader;
                    end
                end
                StHeader: begin
                    if (accept) begin
                        odata_q  <= 8'hF0 | 8'(last_q);
                        ovalid_q <= 1'b1;
                        count_q  <= 8'h00;
                        state_q  <= StData;
                    end
                end
                StData: begin
                    if (take) begin
                        odata_q  <= sel_byte;
                        ovalid_q <= 1'b1;
                        count_q  <= count_q + 8'd1;
                        if (count_q + 8'd1 == BurstMax) begin
`ifdef TX_TRAILER_EN
                            state_q <= StTrailer;
`else
                            state_q <= StIdle;
                            grant_q <= '0;
`endif
                        end
                    end else if (accept) begin
                        // Source gap (or a full burst) ends the frame.
`ifdef TX_TRAILER_EN
                        state_q <= StTrailer;
`else
                        state_q <= StIdle;
                        grant_q <= '0;
`endif
                    end
                end
`ifdef TX_TRAILER_EN
                StTrailer: begin
                    if (accept) begin
                        odata_q  <= count_q;
                        ovalid_q <= 1'b1;
                        state_q  <= StIdle;
                        grant_q  <= '0;
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rs232_tx_scheduler.sv
// Self-checking bench for axis_rs232_tx_scheduler: per-channel source queues, an output
// scoreboard of expected bytes and grants, table-driven single-channel bursts and
// hand-written arbitration / reset / gap sequences.
module tb_axis_rs232_tx_scheduler;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned BURST    = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    axis_rs232_tx_scheduler_if #(.CHANNELS(CHANNELS)) bus ();

    axis_rs232_tx_scheduler #(
        .CHANNELS(CHANNELS),
        .BURST   (BURST)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]          src_q [CHANNELS][$];
    logic [7:0]          exp_q [$];
    logic [CHANNELS-1:0] exp_grant_q [$];
    int                  frames;
    int                  pulses [CHANNELS];
    bit                  rand_ready = 1'b0;
    bit                  mon_en = 1'b0;

    typedef struct {
        int         ch;
        int         len;
        logic [7:0] base;
        logic [7:0] step;
        bit         rnd;
        int         exp_frames;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Queue a source burst and the frames the scheduler must produce from it.
    task automatic push_frames(input int ch, input int len, input logic [7:0] base,
                               input logic [7:0] step);
        logic [7:0] b;
        int         left;
        int         n;
        b    = base;
        left = len;
        for (int i = 0; i < len; i++) begin
            src_q[ch].push_back(base + 8'(i) * step);
        end
        while (left > 0) begin
            n = (left > int'(BURST)) ? int'(BURST) : left;
            exp_grant_q.push_back(CHANNELS'(1) << ch);
            exp_q.push_back(8'hF0 | 8'(ch));
            for (int j = 0; j < n; j++) begin
                exp_q.push_back(b);
                b = b + step;
            end
`ifdef TX_TRAILER_EN
            exp_q.push_back(8'(n));
`endif
            left = left - n;
        end
    endtask

    function automatic bit sources_empty();
        bit e;
        e = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (src_q[c].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !sources_empty() || bus.busy || bus.ovalid) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        if (n >= 3000) fail_now({name, " drain timeout"});
        repeat (3) @(posedge clock);
        #1;
        check({name, " grant idle"}, 32'(bus.grant), 32'h0);
        check({name, " grants left"}, 32'(exp_grant_q.size()), 32'h0);
    endtask

    // One-cycle asynchronous reset pulse; pending output and source data are discarded.
    task automatic do_reset();
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("rst ovalid", 32'(bus.ovalid), 32'h0);
        check("rst odata", 32'(bus.odata), 32'h0);
        check("rst grant", 32'(bus.grant), 32'h0);
        check("rst busy", 32'(bus.busy), 32'h0);
        check("rst iready", 32'(bus.iready), 32'h0);
        exp_q.delete();
        exp_grant_q.delete();
        for (int c = 0; c < CHANNELS; c++) begin
            src_q[c].delete();
            pulses[c] = 0;
        end
        frames = 0;
        @(posedge clock);
        #3 reset = 1'b0;
    endtask

    // Source driver: pop accepted bytes after each edge and present the next ones.
    initial begin
        logic [CHANNELS-1:0]        hs;
        logic [CHANNELS-1:0][7:0]   dv;
        bus.ivalid = '0;
        bus.idata  = '0;
        bus.oready = 1'b1;
        forever begin
            @(negedge clock);
            hs = bus.ivalid & bus.iready;
            @(posedge clock);
            #1;
            if (!reset) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (hs[c]) begin
                        if (src_q[c].size() != 0) void'(src_q[c].pop_front());
                        pulses[c]++;
                    end
                end
            end
            dv = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                bus.ivalid[c] = (src_q[c].size() != 0);
                if (src_q[c].size() != 0) dv[c] = src_q[c][0];
            end
            bus.idata  = dv;
            bus.oready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard compare, hold stability and grant/ready properties.
    initial begin
        bit                  prev_hold;
        logic [7:0]          prev_data;
        logic [CHANNELS-1:0] prev_grant;
        prev_hold  = 1'b0;
        prev_data  = 8'h00;
        prev_grant = '0;
        forever begin
            @(negedge clock);
            if (mon_en && !reset) begin
                check("iready onehot0", 32'($onehot0(bus.iready)), 32'h1);
                check("iready owner", 32'(bus.iready & ~bus.grant), 32'h0);
                check("busy vs grant", 32'(bus.busy), 32'(bus.grant != '0));
                if (prev_hold) begin
                    check("hold ovalid", 32'(bus.ovalid), 32'h1);
                    check("hold odata", 32'(bus.odata), 32'(prev_data));
                end
                if (bus.grant != '0 && prev_grant == '0) begin
                    frames++;
                    check("iready in header", 32'(bus.iready), 32'h0);
                    if (exp_grant_q.size() == 0) fail_now("unexpected grant");
                    else check("grant", 32'(bus.grant), 32'(exp_grant_q.pop_front()));
                end
                if (bus.ovalid && bus.oready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra byte: got %0h expected none", bus.odata);
                    end else begin
                        check("odata", 32'(bus.odata), 32'(exp_q.pop_front()));
                    end
                end
                prev_hold  = bus.ovalid && !bus.oready;
                prev_data  = bus.odata;
                prev_grant = bus.grant;
            end else begin
                prev_hold  = 1'b0;
                prev_grant = '0;
            end
        end
    end

    initial begin
        vecs[0] = '{ch: 1, len: 2,  base: 8'h11, step: 8'h11, rnd: 1'b0, exp_frames: 1};
        vecs[1] = '{ch: 2, len: 20, base: 8'h40, step: 8'h01, rnd: 1'b0, exp_frames: 2};
        vecs[2] = '{ch: 0, len: 5,  base: 8'hA0, step: 8'h03, rnd: 1'b1, exp_frames: 1};
        vecs[3] = '{ch: 3, len: 1,  base: 8'h5A, step: 8'h00, rnd: 1'b0, exp_frames: 1};
        vecs[4] = '{ch: 1, len: 16, base: 8'hF0, step: 8'h01, rnd: 1'b0, exp_frames: 1};
        vecs[5] = '{ch: 0, len: 17, base: 8'h00, step: 8'hFF, rnd: 1'b0, exp_frames: 2};
        vecs[6] = '{ch: 3, len: 33, base: 8'h10, step: 8'h07, rnd: 1'b1, exp_frames: 3};

        do_reset();
        mon_en = 1'b1;

        // Single-channel bursts from the table.
        for (int v = 0; v < NVEC; v++) begin
            frames = 0;
            for (int c = 0; c < CHANNELS; c++) pulses[c] = 0;
            rand_ready = vecs[v].rnd;
            push_frames(vecs[v].ch, vecs[v].len, vecs[v].base, vecs[v].step);
            wait_drain($sformatf("vec%0d", v));
            rand_ready = 1'b0;
            check($sformatf("vec%0d frames", v), 32'(frames), 32'(vecs[v].exp_frames));
            check($sformatf("vec%0d pulses", v), 32'(pulses[vecs[v].ch]), 32'(vecs[v].len));
        end

        // All channels requesting: order 0,1,2,3,0 with full bursts.
        do_reset();
        for (int c = 0; c < CHANNELS; c++) push_frames(c, 16, 8'(c * 16), 8'h01);
        push_frames(0, 16, 8'hC0, 8'h01);
        wait_drain("rr");
        check("rr frames", 32'(frames), 32'd5);
        check("rr ch0 pulses", 32'(pulses[0]), 32'd32);

        // Reset mid-burst on ch3, then ch0 and ch3 compete: ch0 first.
        do_reset();
        push_frames(3, 12, 8'h30, 8'h01);
        begin
            int n;
            n = 0;
            while (exp_q.size() > 8 && n < 500) begin
                @(posedge clock);
                n++;
            end
            if (n >= 500) fail_now("midburst wait timeout");
        end
        do_reset();
        push_frames(0, 3, 8'h01, 8'h01);
        push_frames(3, 3, 8'h31, 8'h01);
        wait_drain("post reset");
        check("post reset frames", 32'(frames), 32'd2);

        // ch1 single byte then gap, ch2 requesting in the same cycle.
        do_reset();
        push_frames(1, 1, 8'h77, 8'h00);
        push_frames(2, 4, 8'h81, 8'h01);
        wait_drain("gap");
        check("gap frames", 32'(frames), 32'd2);
        check("gap ch1 pulses", 32'(pulses[1]), 32'd1);
        check("gap ch2 pulses", 32'(pulses[2]), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
